// File: rtl/axis_vis_serialise_if.sv
// Visibility-in / byte-out stream bundle for axis_vis_serialise; slave is the serialiser's view.
interface axis_vis_serialise_if #(
  parameter int WIDTH = 32,
  parameter int CBITS = 16
);
  logic             s_tvalid_i;
  logic             s_tready_o;
  logic             s_tlast_i;
  logic [WIDTH-1:0] s_tre_i;
  logic [WIDTH-1:0] s_tim_i;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic             m_tlast_o;
  logic [7:0]       m_tdata_o;
  logic             short_o;
  logic             long_o;
  logic [CBITS-1:0] count_o;

  modport slave (
    input  s_tvalid_i, s_tlast_i, s_tre_i, s_tim_i, m_tready_i,
    output s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, short_o, long_o, count_o
  );

  modport master (
    output s_tvalid_i, s_tlast_i, s_tre_i, s_tim_i, m_tready_i,
    input  s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, short_o, long_o, count_o
  );
endinterface

// File: rtl/axis_vis_serialise.sv
// Serialises re/im visibility words into an AXIS byte stream with frame tlast; first byte 1 cycle after accept.
// Backpressure: output held while valid && !ready; a new word is taken on the last byte's handshake, so no bubbles.
module axis_vis_serialise #(
  parameter int WIDTH      = 32,
  parameter int MSB_FIRST  = 1,
  parameter int IMAG_FIRST = 0,
  parameter int COUNT      = 36,
  parameter int CBITS      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  axis_vis_serialise_if.slave  bus
);
  localparam int NC = WIDTH / 8;
  localparam int NB = 2 * NC;
  localparam int IW = $clog2(NB);
  localparam bit FRAMED = (COUNT != 0);
  localparam logic [CBITS-1:0] CLAST = CBITS'((COUNT == 0) ? 0 : COUNT - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]         state;
  logic [2*WIDTH-1:0] sreg;
  logic [IW-1:0]      idx;
  logic               last_word;
  logic [CBITS-1:0]   cnt;
  logic               short_q;
  logic               long_q;

  logic [WIDTH-1:0]   first_c;
  logic [WIDTH-1:0]   second_c;
  logic [2*WIDTH-1:0] load;
  logic               last_byte;
  logic               s_rdy;
  logic               accept;
  logic               at_limit;
  logic               frame_last;

  // Reorder once at load time so the outgoing byte is always sreg[7:0].
  always_comb begin
    first_c  = (IMAG_FIRST != 0) ? bus.s_tim_i : bus.s_tre_i;
    second_c = (IMAG_FIRST != 0) ? bus.s_tre_i : bus.s_tim_i;
    load     = '0;
    for (int k = 0; k < NC; k++) begin
      if (MSB_FIRST != 0) begin
        load[8*k +: 8]      = first_c[WIDTH-1-8*k -: 8];
        load[8*(k+NC) +: 8] = second_c[WIDTH-1-8*k -: 8];
      end else begin
        load[8*k +: 8]      = first_c[8*k +: 8];
        load[8*(k+NC) +: 8] = second_c[8*k +: 8];
      end
    end
  end

  assign last_byte  = (idx == IW'(NB - 1));
  assign s_rdy      = !reset && ((state == EMPTY) || (last_byte && bus.m_tready_i));
  assign accept     = bus.s_tvalid_i && s_rdy;
  assign at_limit   = FRAMED && (cnt == CLAST);
  assign frame_last = bus.s_tlast_i || at_limit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      sreg      <= '0;
      idx       <= '0;
      last_word <= 1'b0;
      cnt       <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      if (accept) begin
        state     <= SHIFT;
        sreg      <= load;
        idx       <= '0;
        last_word <= frame_last;
        cnt       <= frame_last ? '0 : cnt + CBITS'(1);
        short_q   <= FRAMED && bus.s_tlast_i && (cnt < CLAST);
        long_q    <= at_limit && !bus.s_tlast_i;
      end else if (state == SHIFT && bus.m_tready_i) begin
        if (last_byte) begin
          state <= EMPTY;
        end else begin
          sreg <= sreg >> 8;
          idx  <= idx + IW'(1);
        end
      end
    end
  end

  assign bus.s_tready_o = s_rdy;
  assign bus.m_tvalid_o = (state == SHIFT);
  assign bus.m_tlast_o  = (state == SHIFT) && last_byte && last_word;
  assign bus.m_tdata_o  = sreg[7:0];
  assign bus.short_o    = short_q;
  assign bus.long_o     = long_q;
  assign bus.count_o    = cnt;
endmodule
